// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
//   Turns the raw asynchronous system reset into NUM_OUT staggered,
//   clock-synchronous reset releases. Bit 0 is released first.
//   A rising edge on sw_reset_req while running re-runs the HOLD/RELEASE
//   part of the sequence. It does not re-run the synchronizer.
//   Optional feature macro: RESET_RELEASE_SEQUENCER_EVENT_CNT_EN
//   (builds the 16-bit saturating software-reset event counter; otherwise
//   event_count is tied to zero).
module reset_release_sequencer #(
  parameter int NUM_OUT     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sw_reset_req,
  output logic [NUM_OUT-1:0] out_reset,
  output logic               seq_done,
  output logic               sw_reset_ack,
  output logic [15:0]        event_count
);

  // Counter widths, never narrower than one bit.
  localparam int HOLD_W = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = ($clog2(STAGE_GAP + 1) < 1)   ? 1 : $clog2(STAGE_GAP + 1);
  localparam int IDX_W  = ($clog2(NUM_OUT + 1) < 1)     ? 1 : $clog2(NUM_OUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q,    gap_cnt_d;
  logic [IDX_W-1:0]    rel_idx_q,    rel_idx_d;
  logic [NUM_OUT-1:0]  out_reset_q,  out_reset_d;
  logic                seq_done_q,   seq_done_d;
  logic                ack_q,        ack_d;
  logic                sw_pending_q, sw_pending_d;
  logic                req_prev_q;
  logic                sw_edge;

  // ---------------------------------------------------------------------
  // Reset-deassertion synchronizer: each stage is cleared asynchronously
  // and shifts in a constant 1 once reset is low.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      // Stage gi shifts in the previous stage, or 1 for the first stage.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_q[gi] <= 1'b0;
        end else begin
          sync_q[gi] <= (gi == 0) ? 1'b1 : sync_q[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  // The FSM leaves SYNC on the same edge that loads a 1 into the last
  // stage. The feeding stage is therefore watched: SYNC_STAGES edges after
  // reset is released, the last stage and the HOLD entry happen together.
  logic sync_last_loading;
  assign sync_last_loading = sync_q[SYNC_STAGES-2];

  // Rising-edge detect on the software request. The request is assumed
  // synchronous to clock. It is sampled in every state, so a request that
  // is still high when RUN is entered does not retrigger.
  assign sw_edge = sw_reset_req & ~req_prev_q;

  // Edge-detect history register, updated every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_prev_q <= 1'b0;
    end else begin
      req_prev_q <= sw_reset_req;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencing FSM: next state, counters and registered outputs.
  // ---------------------------------------------------------------------
  // Next-state and output logic; defaults hold every register.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    rel_idx_d    = rel_idx_q;
    out_reset_d  = out_reset_q;
    seq_done_d   = seq_done_q;
    sw_pending_d = sw_pending_q;
    ack_d        = 1'b0;

    case (state_q)
      ST_SYNC: begin
        out_reset_d = '1;
        seq_done_d  = 1'b0;
        if (sync_last_loading) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          out_reset_d[0] = 1'b0;
          if (NUM_OUT == 1) begin
            // The single output is released, so the sequence is complete.
            state_d      = ST_RUN;
            seq_done_d   = 1'b1;
            ack_d        = sw_pending_q;
            sw_pending_d = 1'b0;
          end else begin
            state_d   = ST_RELEASE;
            rel_idx_d = IDX_W'(1);
            gap_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          for (int i = 0; i < NUM_OUT; i++) begin
            if (rel_idx_q == IDX_W'(i)) begin
              out_reset_d[i] = 1'b0;
            end
          end
          if (rel_idx_q == IDX_LAST) begin
            // The last bit is released on this edge; RUN starts now.
            state_d      = ST_RUN;
            seq_done_d   = 1'b1;
            ack_d        = sw_pending_q;
            sw_pending_d = 1'b0;
          end else begin
            rel_idx_d = rel_idx_q + 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        seq_done_d = 1'b1;
        if (sw_edge) begin
          // A software reset re-asserts everything and skips the synchronizer.
          out_reset_d  = '1;
          seq_done_d   = 1'b0;
          sw_pending_d = 1'b1;
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
        end
      end

      default: begin
        state_d     = ST_SYNC;
        out_reset_d = '1;
        seq_done_d  = 1'b0;
      end
    endcase
  end

  // FSM state, counters and output registers; reset forces the safe state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      rel_idx_q    <= '0;
      out_reset_q  <= '1;
      seq_done_q   <= 1'b0;
      ack_q        <= 1'b0;
      sw_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      rel_idx_q    <= rel_idx_d;
      out_reset_q  <= out_reset_d;
      seq_done_q   <= seq_done_d;
      ack_q        <= ack_d;
      sw_pending_q <= sw_pending_d;
    end
  end

  assign out_reset    = out_reset_q;
  assign seq_done     = seq_done_q;
  assign sw_reset_ack = ack_q;

  // ---------------------------------------------------------------------
  // Software reset event counter (optional).
  // ---------------------------------------------------------------------
`ifdef RESET_RELEASE_SEQUENCER_EVENT_CNT_EN
  logic [15:0] evt_cnt_q, evt_cnt_d;
  logic        evt_inc;

  // Only requests that are accepted in RUN are counted.
  assign evt_inc   = (state_q == ST_RUN) && sw_edge;
  assign evt_cnt_d = (evt_inc && (evt_cnt_q != 16'hFFFF)) ? evt_cnt_q + 16'd1 : evt_cnt_q;

  // Saturating event counter, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evt_cnt_q <= 16'h0000;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign event_count = evt_cnt_q;
`else
  assign event_count = 16'h0000;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Testbench for reset_release_sequencer: a table of waveform segments
// (default parameters) plus hand-written sequences for asynchronous
// reset and a NUM_OUT=1 / short-timing instance.
module tb_reset_release_sequencer;

`ifdef RESET_RELEASE_SEQUENCER_EVENT_CNT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req;
  logic [2:0]  out_rst;
  logic        done;
  logic        ack;
  logic [15:0] ev;

  logic        rst_b;
  logic        req_b;
  logic [0:0]  out_b;
  logic        done_b;
  logic        ack_b;
  logic [15:0] ev_b;

  int tests = 0;
  int fails = 0;

  reset_release_sequencer #(
    .NUM_OUT(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGE_GAP(4)
  ) dut (
    .clock(clk), .reset(rst), .sw_reset_req(req),
    .out_reset(out_rst), .seq_done(done), .sw_reset_ack(ack), .event_count(ev)
  );

  reset_release_sequencer #(
    .NUM_OUT(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGE_GAP(1)
  ) dut_b (
    .clock(clk), .reset(rst_b), .sw_reset_req(req_b),
    .out_reset(out_b), .seq_done(done_b), .sw_reset_ack(ack_b), .event_count(ev_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One segment: hold req for 'cycles' edges. After each of those edges
  // the outputs must equal the expected values.
  typedef struct {
    int         cycles;
    logic       req;
    logic [2:0] out;
    logic       done;
    logic       ack;
    int         ev;
  } seg_t;

  typedef struct {
    logic [2:0]  out;
    logic        done;
    logic        ack;
    logic [15:0] ev;
  } exp_t;

  seg_t tbl[64];
  int   n_seg = 0;
  exp_t sb[$];

  function automatic void add_seg(input int c, input logic r, input logic [2:0] o,
                                  input logic d, input logic a, input int e);
    tbl[n_seg].cycles = c;
    tbl[n_seg].req    = r;
    tbl[n_seg].out    = o;
    tbl[n_seg].done   = d;
    tbl[n_seg].ack    = a;
    tbl[n_seg].ev     = e;
    n_seg++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive segments [first, last]. Expected values are queued when the
  // stimulus is applied and popped once the DUT has clocked.
  task automatic run_segs(input int first, input int last, input string tag);
    exp_t e;
    for (int s = first; s <= last; s++) begin
      for (int c = 0; c < tbl[s].cycles; c++) begin
        req    = tbl[s].req;
        e.out  = tbl[s].out;
        e.done = tbl[s].done;
        e.ack  = tbl[s].ack;
        e.ev   = EV_EN ? 16'(tbl[s].ev) : 16'h0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("%s seg%0d cyc%0d out_reset", tag, s, c), 32'(out_rst), 32'(e.out));
        chk($sformatf("%s seg%0d cyc%0d seq_done", tag, s, c), 32'(done), 32'(e.done));
        chk($sformatf("%s seg%0d cyc%0d sw_reset_ack", tag, s, c), 32'(ack), 32'(e.ack));
        chk($sformatf("%s seg%0d cyc%0d event_count", tag, s, c), 32'(ev), 32'(e.ev));
      end
    end
    req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " out_reset"}, 32'(out_rst), 32'h7);
    chk({tag, " seq_done"}, 32'(done), 32'h0);
    chk({tag, " sw_reset_ack"}, 32'(ack), 32'h0);
    chk({tag, " event_count"}, 32'(ev), 32'h0);
  endtask

  // Reset asserted for a few edges, then released just after an edge,
  // so the next rising edge is E1.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset held");
    rst = 1'b0;
  endtask

  task automatic step_b(input logic r, input logic o, input logic d, input logic a,
                        input string tag);
    req_b = r;
    @(posedge clk);
    #1;
    chk({tag, " out_reset"}, 32'(out_b), 32'(o));
    chk({tag, " seq_done"}, 32'(done_b), 32'(d));
    chk({tag, " sw_reset_ack"}, 32'(ack_b), 32'(a));
  endtask

  int po_a, po_b, sw_a, sw_b, hd_a, hd_b, ig_a, ig_b, pp_a, pp_b, st_a, st_b;

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    rst_b = 1'b1;
    req_b = 1'b0;

    // Power-on: 111 through E17, bit0 at E18, bit1 at E22, bit2 and done at E26.
    po_a = n_seg;
    add_seg(17, 1'b0, 3'b111, 1'b0, 1'b0, 0);
    add_seg(4,  1'b0, 3'b110, 1'b0, 1'b0, 0);
    add_seg(4,  1'b0, 3'b100, 1'b0, 1'b0, 0);
    add_seg(3,  1'b0, 3'b000, 1'b1, 1'b0, 0);
    po_b = n_seg - 1;

    // Software pulse at Ek: releases at Ek+16/+20/+24, ack after Ek+24.
    sw_a = n_seg;
    add_seg(1,  1'b1, 3'b111, 1'b0, 1'b0, 1);
    add_seg(15, 1'b0, 3'b111, 1'b0, 1'b0, 1);
    add_seg(4,  1'b0, 3'b110, 1'b0, 1'b0, 1);
    add_seg(4,  1'b0, 3'b100, 1'b0, 1'b0, 1);
    add_seg(1,  1'b0, 3'b000, 1'b1, 1'b1, 1);
    add_seg(3,  1'b0, 3'b000, 1'b1, 1'b0, 1);
    sw_b = n_seg - 1;

    // Request held high for 40 cycles: exactly one sequence and one ack.
    hd_a = n_seg;
    add_seg(1,  1'b1, 3'b111, 1'b0, 1'b0, 2);
    add_seg(15, 1'b1, 3'b111, 1'b0, 1'b0, 2);
    add_seg(4,  1'b1, 3'b110, 1'b0, 1'b0, 2);
    add_seg(4,  1'b1, 3'b100, 1'b0, 1'b0, 2);
    add_seg(1,  1'b1, 3'b000, 1'b1, 1'b1, 2);
    add_seg(15, 1'b1, 3'b000, 1'b1, 1'b0, 2);
    add_seg(3,  1'b0, 3'b000, 1'b1, 1'b0, 2);
    hd_b = n_seg - 1;

    // A second pulse during HOLD is ignored: same timing, count unchanged.
    ig_a = n_seg;
    add_seg(1,  1'b1, 3'b111, 1'b0, 1'b0, 3);
    add_seg(5,  1'b0, 3'b111, 1'b0, 1'b0, 3);
    add_seg(1,  1'b1, 3'b111, 1'b0, 1'b0, 3);
    add_seg(9,  1'b0, 3'b111, 1'b0, 1'b0, 3);
    add_seg(4,  1'b0, 3'b110, 1'b0, 1'b0, 3);
    add_seg(4,  1'b0, 3'b100, 1'b0, 1'b0, 3);
    add_seg(1,  1'b0, 3'b000, 1'b1, 1'b1, 3);
    add_seg(2,  1'b0, 3'b000, 1'b1, 1'b0, 3);
    ig_b = n_seg - 1;

    // Power-on cut short at E20 (bit0 already released).
    pp_a = n_seg;
    add_seg(17, 1'b0, 3'b111, 1'b0, 1'b0, 0);
    add_seg(3,  1'b0, 3'b110, 1'b0, 1'b0, 0);
    pp_b = n_seg - 1;

    // Software sequence started, later cut by a hardware reset.
    st_a = n_seg;
    add_seg(1,  1'b1, 3'b111, 1'b0, 1'b0, 1);
    add_seg(5,  1'b0, 3'b111, 1'b0, 1'b0, 1);
    st_b = n_seg - 1;

    #1;
    chk_reset_vals("async reset at t0");

    do_reset();
    run_segs(po_a, po_b, "power-on");
    run_segs(sw_a, sw_b, "sw pulse");
    run_segs(hd_a, hd_b, "held req");
    run_segs(ig_a, ig_b, "ignored req");

    // Mid-sequence asynchronous reset: outputs return without a clock edge.
    do_reset();
    run_segs(pp_a, pp_b, "partial power-on");
    rst = 1'b1;
    #2;
    chk_reset_vals("async reset mid-seq");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_segs(po_a, po_b, "power-on after mid reset");

    // A pending software sequence is lost on hardware reset: no ack later.
    run_segs(st_a, st_b, "sw start");
    rst = 1'b1;
    #2;
    chk_reset_vals("async reset in sw hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_segs(po_a, po_b, "power-on after sw abort");

    // NUM_OUT=1, SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=1: change at E4.
    #1;
    rst_b = 1'b0;
    step_b(1'b0, 1'b1, 1'b0, 1'b0, "sweep E1");
    step_b(1'b0, 1'b1, 1'b0, 1'b0, "sweep E2");
    step_b(1'b0, 1'b1, 1'b0, 1'b0, "sweep E3");
    step_b(1'b0, 1'b0, 1'b1, 1'b0, "sweep E4");
    step_b(1'b0, 1'b0, 1'b1, 1'b0, "sweep E5");
    step_b(1'b1, 1'b1, 1'b0, 1'b0, "sweep sw Ek");
    step_b(1'b0, 1'b0, 1'b1, 1'b1, "sweep sw Ek+1");
    step_b(1'b0, 1'b0, 1'b1, 1'b0, "sweep sw Ek+2");
    chk("sweep event_count", 32'(ev_b), EV_EN ? 32'h1 : 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
Name: reset_release_sequencer

Overview:
Sits directly upstream of the fixed clock broadcast stage and generates the reset it fans out alongside the clock.
- Takes the raw asynchronous system reset.
- Synchronizes its deassertion to `clock`.
- Holds reset for a programmable number of cycles.
- Releases NUM_OUT reset outputs in a fixed, staggered order, so downstream domains leave reset deterministically.
- Accepts a software-initiated reset request and re-runs the same sequence.

Parameters:
- NUM_OUT, 3: number of sequenced reset outputs (>=1).
- SYNC_STAGES, 2: flops in the reset-deassertion synchronizer (>=2).
- HOLD_CYCLES, 16: cycles all outputs stay asserted after the synchronized release (>=1).
- STAGE_GAP, 4: cycles between release of consecutive outputs (>=1).

Ports:
- clock  input  1  single block clock.
- reset  input  1  asynchronous, active-high reset.
- sw_reset_req  input  1  software reset request; rising-edge sensitive.
- out_reset  output  NUM_OUT  sequenced active-high resets; bit 0 is released first.
- seq_done  output  1  high while all outputs are released (RUN state).
- sw_reset_ack  output  1  one-cycle pulse when a software-initiated sequence completes.
- event_count  output  16  software reset event count (see Optional Feature).

Behaviour:
- Interface (already decided): one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset asserted:
  - Immediately (asynchronously): out_reset = all ones, seq_done = 0, sw_reset_ack = 0, event_count = 0.
  - Synchronizer chain, counters and the FSM are cleared to SYNC; the req edge-detect register is cleared to 0.
- Synchronizer: a chain of SYNC_STAGES flops, asynchronously cleared by reset, shifting in 1 each edge. The FSM may leave SYNC only when the last stage is 1.
- FSM states:
  - SYNC: outputs all asserted. When the last sync stage becomes 1, go to HOLD with counter = 0.
  - HOLD: counter increments each cycle. After HOLD_CYCLES cycles in HOLD, clear out_reset[0] and go to RELEASE with stage index = 1 and gap counter = 0.
  - RELEASE: after STAGE_GAP cycles, clear out_reset[index] and increment index. When the last bit is cleared, go to RUN on the same edge. If NUM_OUT = 1, HOLD goes directly to RUN.
  - RUN: seq_done = 1. A rising edge of sw_reset_req (req = 1 and previous sample = 0) sets out_reset to all ones and seq_done to 0, latches a sw_pending flag, and goes to HOLD. The synchronizer is not re-run.
- Timing with defaults, E1 = first rising edge with reset low:
  - out_reset[0] falls at E18 (SYNC_STAGES + HOLD_CYCLES).
  - out_reset[1] falls at E22; out_reset[2] falls at E26.
  - seq_done rises at E26.
- sw_reset_ack:
  - Asserted for exactly one cycle, registered on the same edge as the entry to RUN, only if sw_pending is set.
  - sw_pending clears on that same edge.
- sw_reset_req outside RUN:
  - Rising edges in SYNC/HOLD/RELEASE are ignored and are not queued.
  - The edge detector keeps sampling in all states, so a request held high across RUN entry does not retrigger.
- Output stability:
  - out_reset bits only ever fall in index order and only rise together.
  - No output is combinationally derived from sw_reset_req.
  - All outputs are registered.
- reset asserted mid-sequence (any state): immediate return to the reset values above, and sw_pending is lost.
- Counter widths: clog2 of HOLD_CYCLES+1, STAGE_GAP+1 and NUM_OUT+1, minimum 1 bit.

Optional Feature:
- Macro: RESET_RELEASE_SEQUENCER_EVENT_CNT_EN.
- Defined:
  - event_count is a 16-bit register, incremented on every accepted sw_reset_req rising edge (RUN state only).
  - Saturates at 0xFFFF; cleared only by reset.
- Undefined:
  - event_count is tied to 0; no counter logic is built.
  - All other behaviour is identical.

Test Plan:
- Power-on, defaults: assert reset 3 cycles, release before E1 -> out_reset = 3'b111 through E17; bit0 low at E18, bit1 at E22, bit2 at E26; seq_done rises at E26; sw_reset_ack stays 0.
- Software reset: in RUN, pulse sw_reset_req at edge Ek -> out_reset = 3'b111 after Ek; bits release at Ek+16, Ek+20, Ek+24; sw_reset_ack high for one cycle after Ek+24; event_count = 1 if the macro is defined, else 0.
- Held request: hold sw_reset_req high for 40 cycles from RUN -> exactly one sequence, one ack, event_count = 1.
- Ignored request: pulse sw_reset_req during HOLD -> no extension of the sequence, no ack, event_count unchanged.
- Mid-sequence reset: assert reset asynchronously at E20 (bit0 already released) -> out_reset = 3'b111 immediately without a clock edge; after release the full power-on timing repeats from the new E1.
- Parameter sweep NUM_OUT=1, HOLD_CYCLES=1, STAGE_GAP=1, SYNC_STAGES=3 -> out_reset[0] and seq_done change at E4.
